turn_sequencer: RTL and testbench

- Parametrised N-player turn manager; next generation of the two-player tank game FSM.
- Sequences start screen, per-player shoot/flight turns, elimination checks, end-of-game timer and result display.
- Eliminated players (health 0) are skipped in round-robin order; an optional per-turn timeout forfeits idle turns.
- Sits between the keyboard/bullet logic and the display/HUD logic; clocked on the frame clock.

---
 rtl/turn_sequencer.sv | 168 ++++++++++++++++
 tb/tb_turn_sequencer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/turn_sequencer.sv
// turn_sequencer: N-player turn manager for the tank game.
// It moves through the start screen, each player's shoot and bullet-flight
// phases, the elimination check, the end-of-game wait and the result screen.
// Players with zero health are skipped in round-robin order.
// Optional macro TURN_TIMEOUT_EN: an ARM phase that reaches TURN_FRAMES
// frames without a shot forfeits the turn.
// State table:
//   INIT    | one cycle after reset
//   START   | start screen, waiting for game_start
//   ARM     | current player may fire
//   FLIGHT  | bullet in the air, waiting for stop
//   SETTLE  | one cycle so the health update can land
//   CHECK   | count the turn, then elect a winner or pick the next player
//   ENDWAIT | final timer running, waiting for endgame
//   RESULT  | winner/draw shown until restart
module turn_sequencer #(
  parameter int NUM_PLAYERS = 2,
  parameter int HEALTH_W    = 4,
  parameter int TURN_FRAMES = 600,
  parameter int PIDX_W      = $clog2(NUM_PLAYERS)
) (
  input  logic                            frame_clk,
  input  logic                            Reset,
  input  logic                            game_start,
  input  logic [NUM_PLAYERS-1:0]          shoot,
  input  logic [NUM_PLAYERS-1:0]          stop,
  input  logic [NUM_PLAYERS*HEALTH_W-1:0] health,
  input  logic                            endgame,
  input  logic                            restart,
  output logic [NUM_PLAYERS-1:0]          turn_onehot,
  output logic [PIDX_W-1:0]               turn_idx,
  output logic                            in_flight,
  output logic                            startscreen,
  output logic                            startfinaltimer,
  output logic [NUM_PLAYERS-1:0]          winner_onehot,
  output logic                            draw,
  output logic [7:0]                      round_cnt
);

  typedef enum logic [2:0] {
    S_INIT, S_START, S_ARM, S_FLIGHT, S_SETTLE, S_CHECK, S_ENDWAIT, S_RESULT
  } state_t;

  state_t                  state_q;
  logic [PIDX_W-1:0]       turn_idx_q;
  logic [7:0]              round_cnt_q;
  logic [NUM_PLAYERS-1:0]  winner_q;

  logic [NUM_PLAYERS-1:0]  alive;
  logic [PIDX_W-1:0]       first_alive_d;
  logic [PIDX_W-1:0]       next_alive_d;
  logic [PIDX_W-1:0]       cand;
  logic                    found;

`ifdef TURN_TIMEOUT_EN
  localparam int TMR_W = $clog2(TURN_FRAMES) + 1;
  logic [TMR_W-1:0]        timer_q;
`else
  logic                    unused_turn_frames;
  assign unused_turn_frames = (TURN_FRAMES != 0);
`endif

  // A player is alive while its health field is non-zero.
  always_comb begin
    alive = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      alive[i] = |health[i*HEALTH_W +: HEALTH_W];
    end
  end

  // Lowest alive index (0 when nobody is alive) for the first turn of a game.
  always_comb begin
    first_alive_d = '0;
    for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
      if (alive[i]) first_alive_d = PIDX_W'(i);
    end
  end

  // First alive index strictly after the current player, wrapping around.
  always_comb begin
    next_alive_d = turn_idx_q;
    found        = 1'b0;
    cand         = '0;
    for (int k = 1; k < NUM_PLAYERS; k++) begin
      cand = PIDX_W'((int'(turn_idx_q) + k) % NUM_PLAYERS);
      if (!found && alive[cand]) begin
        next_alive_d = cand;
        found        = 1'b1;
      end
    end
  end

  // Turn sequencing FSM with its turn index, round counter and winner latch.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= S_INIT;
      turn_idx_q  <= '0;
      round_cnt_q <= '0;
      winner_q    <= '0;
`ifdef TURN_TIMEOUT_EN
      timer_q     <= '0;
`endif
    end else begin
`ifdef TURN_TIMEOUT_EN
      // Cleared in every state; only a continuing ARM phase advances it.
      timer_q <= '0;
`endif
      case (state_q)
        S_INIT: state_q <= S_START;
        S_START: begin
          if (game_start) begin
            state_q     <= S_ARM;
            turn_idx_q  <= first_alive_d;
            round_cnt_q <= '0;
          end
        end
        S_ARM: begin
          if (shoot[turn_idx_q]) begin
            state_q <= S_FLIGHT;
          end
`ifdef TURN_TIMEOUT_EN
          else if (timer_q == TMR_W'(TURN_FRAMES - 1)) begin
            state_q <= S_SETTLE;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
`endif
        end
        S_FLIGHT: begin
          if (stop[turn_idx_q]) state_q <= S_SETTLE;
        end
        S_SETTLE: state_q <= S_CHECK;
        S_CHECK: begin
          if (round_cnt_q != 8'hFF) round_cnt_q <= round_cnt_q + 8'd1;
          if ($countones(alive) <= 1) begin
            winner_q <= alive;
            state_q  <= S_ENDWAIT;
          end else begin
            turn_idx_q <= next_alive_d;
            state_q    <= S_ARM;
          end
        end
        S_ENDWAIT: begin
          if (endgame) state_q <= S_RESULT;
        end
        S_RESULT: begin
          if (restart) begin
            winner_q <= '0;
            state_q  <= S_START;
          end
        end
        default: state_q <= S_START;
      endcase
    end
  end

  // Outputs are pure decodes of the registered state, never of inputs.
  assign turn_onehot     = (state_q == S_ARM)
                           ? ({{(NUM_PLAYERS-1){1'b0}}, 1'b1} << turn_idx_q) : '0;
  assign turn_idx        = turn_idx_q;
  assign in_flight       = (state_q == S_FLIGHT);
  assign startscreen     = (state_q == S_START);
  assign startfinaltimer = (state_q == S_ENDWAIT);
  assign winner_onehot   = (state_q == S_RESULT) ? winner_q : '0;
  assign draw            = (state_q == S_RESULT) && (winner_q == '0);
  assign round_cnt       = round_cnt_q;

endmodule

// File: tb/tb_turn_sequencer.sv
// Directed bench for turn_sequencer with four players.
module tb_turn_sequencer;

  localparam int NP = 4;
  localparam int HW = 4;

  logic           frame_clk;
  logic           Reset;
  logic           game_start;
  logic [NP-1:0]  shoot;
  logic [NP-1:0]  stop;
  logic [NP*HW-1:0] health;
  logic           endgame;
  logic           restart;
  logic [NP-1:0]  turn_onehot;
  logic [1:0]     turn_idx;
  logic           in_flight;
  logic           startscreen;
  logic           startfinaltimer;
  logic [NP-1:0]  winner_onehot;
  logic           draw;
  logic [7:0]     round_cnt;

  int total = 0;
  int bad   = 0;

  turn_sequencer #(
    .NUM_PLAYERS(NP),
    .HEALTH_W(HW),
    .TURN_FRAMES(10)
  ) dut (
    .frame_clk(frame_clk),
    .Reset(Reset),
    .game_start(game_start),
    .shoot(shoot),
    .stop(stop),
    .health(health),
    .endgame(endgame),
    .restart(restart),
    .turn_onehot(turn_onehot),
    .turn_idx(turn_idx),
    .in_flight(in_flight),
    .startscreen(startscreen),
    .startfinaltimer(startfinaltimer),
    .winner_onehot(winner_onehot),
    .draw(draw),
    .round_cnt(round_cnt)
  );

  initial begin
    frame_clk = 1'b0;
    forever #5 frame_clk = ~frame_clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge frame_clk);
    #1;
  endtask

  function automatic logic [NP*HW-1:0] hv(input int h0, input int h1, input int h2, input int h3);
    return {HW'(h3), HW'(h2), HW'(h1), HW'(h0)};
  endfunction

  initial begin
    Reset = 1'b1; game_start = 1'b1; shoot = '0; stop = '0;
    endgame = 1'b0; restart = 1'b0; health = hv(5, 5, 5, 5);
    repeat (2) tick();
    chk("rst_onehot", 32'(turn_onehot), 32'h0);
    chk("rst_round", 32'(round_cnt), 32'h0);
    chk("rst_idx", 32'(turn_idx), 32'h0);
    chk("rst_start", 32'(startscreen), 32'h0);
    chk("rst_win", 32'(winner_onehot), 32'h0);

    // INIT for one cycle, then START, then ARM for player 0
    Reset = 1'b0;
    chk("init_start", 32'(startscreen), 32'h0);
    tick();
    chk("start_scr", 32'(startscreen), 32'h1);
    tick();
    game_start = 1'b0;
    chk("arm0_onehot", 32'(turn_onehot), 32'h1);
    chk("arm0_idx", 32'(turn_idx), 32'h0);
    chk("arm0_start", 32'(startscreen), 32'h0);

    // player 0: shot, four FLIGHT cycles, SETTLE, CHECK, ARM player 1
    shoot = 4'b0001; tick(); shoot = '0;
    chk("p0_flight", 32'(in_flight), 32'h1);
    repeat (3) tick();
    chk("p0_flight4", 32'(in_flight), 32'h1);
    stop = 4'b0001; tick(); stop = '0;
    chk("p0_settle_fl", 32'(in_flight), 32'h0);
    chk("p0_settle_oh", 32'(turn_onehot), 32'h0);
    tick();
    chk("p0_check_rnd", 32'(round_cnt), 32'h0);
    tick();
    chk("p1_onehot", 32'(turn_onehot), 32'h2);
    chk("p1_round", 32'(round_cnt), 32'h1);

    // foreign flags in player 1's ARM change nothing
    shoot = 4'b0100; stop = 4'b0001; tick();
    chk("foreign_oh", 32'(turn_onehot), 32'h2);
    chk("foreign_fl", 32'(in_flight), 32'h0);
    // own stop in the shot cycle is ignored
    shoot = 4'b0010; stop = 4'b0010; tick();
    shoot = '0; stop = '0; health = hv(5, 5, 0, 5);
    chk("p1_flight", 32'(in_flight), 32'h1);
    tick();
    chk("p1_flight2", 32'(in_flight), 32'h1);
    stop = 4'b0010; tick(); stop = '0;
    tick(); tick();
    chk("skip_idx", 32'(turn_idx), 32'h3);
    chk("skip_onehot", 32'(turn_onehot), 32'h8);
    chk("skip_round", 32'(round_cnt), 32'h2);

    // player 3 then wrap to player 0
    shoot = 4'b1000; tick(); shoot = '0;
    stop = 4'b1000; tick(); stop = '0;
    tick(); tick();
    chk("wrap_idx", 32'(turn_idx), 32'h0);
    chk("wrap_onehot", 32'(turn_onehot), 32'h1);
    chk("wrap_round", 32'(round_cnt), 32'h3);

    // elimination: only player 0 survives
    shoot = 4'b0001; tick(); shoot = '0;
    health = hv(2, 0, 0, 0);
    stop = 4'b0001; tick(); stop = '0;
    tick(); tick();
    chk("end_timer", 32'(startfinaltimer), 32'h1);
    chk("end_round", 32'(round_cnt), 32'h4);
    chk("end_win_hidden", 32'(winner_onehot), 32'h0);
    endgame = 1'b1; tick(); endgame = 1'b0;
    chk("res_win", 32'(winner_onehot), 32'h1);
    chk("res_draw", 32'(draw), 32'h0);
    chk("res_timer", 32'(startfinaltimer), 32'h0);
    restart = 1'b1; tick(); restart = 1'b0;
    chk("restart_scr", 32'(startscreen), 32'h1);
    chk("restart_win", 32'(winner_onehot), 32'h0);

    // everyone dies in the same shot: draw
    health = hv(5, 5, 5, 5);
    game_start = 1'b1; tick(); game_start = 1'b0;
    chk("g2_round", 32'(round_cnt), 32'h0);
    chk("g2_onehot", 32'(turn_onehot), 32'h1);
    shoot = 4'b0001; tick(); shoot = '0;
    health = hv(0, 0, 0, 0);
    stop = 4'b0001; tick(); stop = '0;
    tick(); tick();
    chk("dead_timer", 32'(startfinaltimer), 32'h1);
    endgame = 1'b1; tick(); endgame = 1'b0;
    chk("dead_win", 32'(winner_onehot), 32'h0);
    chk("dead_draw", 32'(draw), 32'h1);

    // player 0 dead at start: first turn goes to player 1
    restart = 1'b1; health = hv(0, 5, 5, 5); tick(); restart = 1'b0;
    game_start = 1'b1; tick(); game_start = 1'b0;
    chk("g3_idx", 32'(turn_idx), 32'h1);
    shoot = 4'b0010; tick(); shoot = '0;
    stop = 4'b0010; tick(); stop = '0;
    tick(); tick();
    chk("g3_next", 32'(turn_idx), 32'h2);
    chk("g3_round", 32'(round_cnt), 32'h1);

    // asynchronous reset during FLIGHT
    shoot = 4'b0100; tick(); shoot = '0;
    chk("g3_flight", 32'(in_flight), 32'h1);
    #2 Reset = 1'b1;
    #1;
    chk("arst_round", 32'(round_cnt), 32'h0);
    chk("arst_flight", 32'(in_flight), 32'h0);
    chk("arst_idx", 32'(turn_idx), 32'h0);
    tick();
    Reset = 1'b0;
    chk("arst_init", 32'(startscreen), 32'h0);
    tick();
    chk("arst_start", 32'(startscreen), 32'h1);

    // idle ARM: forfeits on the tenth cycle with the timeout, else waits
    health = hv(5, 5, 5, 5);
    game_start = 1'b1; tick(); game_start = 1'b0;
    chk("to_arm", 32'(turn_onehot), 32'h1);
    repeat (9) tick();
    chk("to_arm10", 32'(turn_onehot), 32'h1);
`ifdef TURN_TIMEOUT_EN
    tick();
    chk("to_settle", 32'(turn_onehot), 32'h0);
    chk("to_noflight", 32'(in_flight), 32'h0);
    tick(); tick();
    chk("to_next", 32'(turn_onehot), 32'h2);
    chk("to_round", 32'(round_cnt), 32'h1);
`else
    repeat (3) tick();
    chk("nto_wait", 32'(turn_onehot), 32'h1);
    chk("nto_round", 32'(round_cnt), 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
